alu_issue_ctrl: RTL

Sequential front-end that drives the 16-bit lookahead ALU's FS/A/B/C_in inputs and consumes its F/Cout outputs. It accepts one command at a time over a valid/ready handshake and reads operands from an internal 8x16 register file. Each command issues one or more ALU operations and writes F back to a destination register. Multi-bit shifts are built from repeated single-bit ALU shifts. The block sits between a host or sequencer and the ALU.

---
 rtl/alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequential front-end for the 16-bit lookahead ALU. It accepts one command
// at a time over a valid/ready handshake, reads its operands from an internal
// register file, and drives the ALU function select, operands and carry-in
// from registers. The ALU result is written back to a destination register.
// Multi-bit shifts are built by feeding the ALU's single-bit shift result
// back into operand A once per cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (ready == block idle)
//   cmd_op, cmd_rd, cmd_ra,
//   cmd_rb, cmd_amt             opcode, dest/src registers, shift count
//   wr_en, wr_addr, wr_data     host register write (honoured only when idle)
//   rd_addr / rd_data           combinational host register read
//   alu_fs, alu_a, alu_b,
//   alu_cin                     registered ALU inputs
//   alu_f, alu_cout             ALU result and carry-out
//   done, err                   retire pulse, illegal-op pulse
//   carry                       sticky carry from the arithmetic ops
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_ra,
    input  logic [2:0]       cmd_rb,
    input  logic [3:0]       cmd_amt,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [4:0]       alu_fs,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic             done,
    output logic             err,
    output logic             carry
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef struct packed {
        logic       legal;
        logic       arith;
        logic       shift;
        logic       cin;
        logic [4:0] fs;
    } dec_t;

    // Opcode to ALU function-select / carry-in map.
    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '{legal: 1'b1, arith: 1'b0, shift: 1'b0, cin: 1'b0, fs: 5'b00000};
        case (op)
            4'd0:    begin d.fs = 5'b10000; d.cin = 1'b1; d.arith = 1'b1; end
            4'd1:    begin d.fs = 5'b10100;               d.arith = 1'b1; end
            4'd2:    begin d.fs = 5'b10110; d.cin = 1'b1; d.arith = 1'b1; end
            4'd3:    begin d.fs = 5'b10010;               d.arith = 1'b1; end
            4'd4:    begin d.fs = 5'b10001; d.cin = 1'b1; d.arith = 1'b1; end
            4'd5:    d.fs = 5'b00000;
            4'd6:    d.fs = 5'b01100;
            4'd7:    d.fs = 5'b00011;
            4'd8:    d.fs = 5'b01000;
            4'd9:    d.fs = 5'b01110;
            4'd10:   d.fs = 5'b00110;
            4'd11:   d.fs = 5'b01111;
            4'd12:   begin d.fs = 5'b11000; d.shift = 1'b1; end
            4'd13:   begin d.fs = 5'b11001; d.shift = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [3:0]       op_q,      op_d;
    logic [2:0]       rd_q,      rd_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [4:0]       alu_fs_q,  alu_fs_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    dec_t cmd_dec;
    dec_t exec_dec;

    assign cmd_dec  = decode(cmd_op);
    assign exec_dec = decode(op_q);

    // alu_a_q doubles as the accumulator: during a multi-bit shift each
    // partial result is fed straight back into operand A. cnt_q holds the
    // number of ALU passes still to go, including the one on the ALU now,
    // so a count of 1 means the current ALU result is final.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        alu_fs_d  = alu_fs_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        regs_d    = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                end
                if (cmd_valid) begin
                    op_d = cmd_op;
                    rd_d = cmd_rd;
                    if (cmd_dec.legal) begin
                        alu_a_d   = regs_q[cmd_ra];
                        alu_b_d   = regs_q[cmd_rb];
                        alu_fs_d  = cmd_dec.fs;
                        alu_cin_d = cmd_dec.cin;
                        cnt_d     = (cmd_dec.shift && cmd_amt != 4'd0) ? cmd_amt : 4'd1;
                        state_d   = ST_EXEC;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q <= 4'd1) begin
                    regs_d[rd_q] = alu_f;
                    if (exec_dec.arith) begin
                        carry_d = alu_cout;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    alu_a_d = alu_f;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            alu_fs_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            carry_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            alu_fs_q  <= alu_fs_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            done_q    <= done_d;
            err_q     <= err_d;
            carry_q   <= carry_d;
            regs_q    <= regs_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rd_data   = regs_q[rd_addr];
    assign alu_fs    = alu_fs_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign done      = done_q;
    assign err       = err_q;
    assign carry     = carry_q;

endmodule
